// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard unit: load-use stall with LOAD_LAT-deep shadow pipe, plus mult/div
// issue/busy sequencing with a timeout watchdog. Define MD_SCOREBOARD_EN for dependency-aware mult/div stall.
module hazard_stall_unit #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned TO_W       = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        md_ready,
  input  logic        flush,
  output logic        stall,
  output logic        md_start,
  output logic        md_busy,
  output logic [4:0]  md_rd,
  output logic        md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // At least one shadow entry is always declared; hits are masked when LOAD_LAT is 1.
  localparam int unsigned SH_D    = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic [4:0] src_a, src_b;
  logic       dx_lw, dx_md;
  logic       sh_hit, load_stall, md_stall, md_dep;
  logic       unused_bits;

  state_t               state_q, state_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [4:0]           md_rd_q, md_rd_d;
  logic [SH_D-1:0]      sh_v_q, sh_v_d;
  logic [SH_D-1:0][4:0] sh_rd_q, sh_rd_d;

  assign fd_op  = fd_ir[31:27];
  assign fd_rd  = fd_ir[26:22];
  assign fd_rs  = fd_ir[21:17];
  assign fd_rt  = fd_ir[16:12];
  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign dx_alu = dx_ir[6:2];

  assign unused_bits = ^{fd_ir, dx_ir};

  assign dx_lw = (dx_op == OP_LW);
  assign dx_md = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

  // Register 0 doubles as "no source", since r0 never creates a hazard.
  always_comb begin
    src_a = '0;
    src_b = '0;
    case (fd_op)
      OP_RTYPE: begin
        src_a = fd_rs;
        src_b = fd_rt;
      end
      OP_ADDI, OP_LW: src_a = fd_rs;
      OP_SW: begin
        src_a = fd_rs;
        src_b = fd_rd;
      end
      OP_BNE, OP_BLT: begin
        src_a = fd_rd;
        src_b = fd_rs;
      end
      OP_JR:  src_a = fd_rd;
      OP_BEX: src_a = 5'd30;
      default: ;
    endcase
  end

  function automatic logic reads(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != 5'd0) && ((r == a) || (r == b));
  endfunction

  always_comb begin
    sh_hit = 1'b0;
    for (int unsigned i = 0; i < SH_D; i++) begin
      if ((LOAD_LAT > 1) && sh_v_q[i] && reads(sh_rd_q[i], src_a, src_b)) begin
        sh_hit = 1'b1;
      end
    end
  end

  assign load_stall = !flush && ((dx_lw && reads(dx_rd, src_a, src_b)) || sh_hit);

  always_comb begin
    sh_v_d  = '0;
    sh_rd_d = '0;
    if (!flush && dx_lw) begin
      sh_v_d[0]  = 1'b1;
      sh_rd_d[0] = dx_rd;
    end
    for (int unsigned i = 1; i < SH_D; i++) begin
      sh_v_d[i]  = sh_v_q[i-1] && !flush;
      sh_rd_d[i] = sh_rd_q[i-1];
    end
  end

`ifdef MD_SCOREBOARD_EN
  logic fd_md, fd_waw;
  assign fd_md  = (fd_op == OP_RTYPE) && ((fd_ir[6:2] == ALU_MUL) || (fd_ir[6:2] == ALU_DIV));
  assign fd_waw = ((fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW)) &&
                  (fd_rd == md_rd_q);
  // Structural conflicts (another mult/div) block regardless of md_rd.
  assign md_dep = fd_md || dx_md ||
                  ((md_rd_q != 5'd0) && (reads(md_rd_q, src_a, src_b) || fd_waw));
`else
  assign md_dep = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_rd_d    = md_rd_q;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    md_stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dx_md && !flush) begin
          md_start = 1'b1;
          md_stall = 1'b1;
          md_rd_d  = dx_rd;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + TO_W'(1);
        if (md_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          md_timeout = 1'b1;
          state_d    = S_IDLE;
        end else begin
          md_stall = md_dep;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
      sh_v_q  <= '0;
      sh_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
      sh_v_q  <= sh_v_d;
      sh_rd_q <= sh_rd_d;
    end
  end

  assign md_busy = (state_q == S_BUSY);
  assign md_rd   = md_rd_q;
  assign stall   = load_stall || md_stall;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one LOAD_LAT=1 and one LOAD_LAT=3 instance on shared inputs.
module tb_hazard_stall_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] fd_ir, dx_ir;
  logic        md_ready, flush;

  logic       stall1, md_start1, md_busy1, md_timeout1;
  logic [4:0] md_rd1;
  logic       stall3, md_start3, md_busy3, md_timeout3;
  logic [4:0] md_rd3;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MD_SCOREBOARD_EN
  localparam logic BLK = 1'b0;
`else
  localparam logic BLK = 1'b1;
`endif

  always #5 clock = ~clock;

  hazard_stall_unit #(.LOAD_LAT(1), .MD_TIMEOUT(8), .TO_W(7)) u_d1 (
    .clock(clock), .reset_n(reset_n), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .md_ready(md_ready), .flush(flush), .stall(stall1), .md_start(md_start1),
    .md_busy(md_busy1), .md_rd(md_rd1), .md_timeout(md_timeout1)
  );

  hazard_stall_unit #(.LOAD_LAT(3), .MD_TIMEOUT(8), .TO_W(7)) u_d3 (
    .clock(clock), .reset_n(reset_n), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .md_ready(md_ready), .flush(flush), .stall(stall3), .md_start(md_start3),
    .md_busy(md_busy3), .md_rd(md_rd3), .md_timeout(md_timeout3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  localparam logic [4:0] LW = 5'b01000, ADDI = 5'b00101, SW = 5'b00111;
  localparam logic [31:0] NOP = 32'h0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic drain();
    fd_ir = NOP; dx_ir = NOP; md_ready = 1'b0; flush = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n = 1'b0; fd_ir = NOP; dx_ir = NOP; md_ready = 1'b0; flush = 1'b0;
    #2;
    check("rst_busy", md_busy1, 0);
    check("rst_timeout", md_timeout1, 0);
    check("rst_md_rd", md_rd1, 0);
    check("rst_stall", stall3, 0);
    dx_ir = itype(LW, 5'd3, 5'd1, 17'd0); fd_ir = rtype(5'd4, 5'd3, 5'd5, 5'd0);
    #1;
    check("rst_ld_term", stall1, 1);
    dx_ir = NOP; fd_ir = NOP;
    settle(); reset_n = 1'b1;
    tick();

    // lw r3 then add r4,r3,r5 directly behind
    dx_ir = itype(LW, 5'd3, 5'd1, 17'd0); fd_ir = rtype(5'd4, 5'd3, 5'd5, 5'd0);
    settle(); check("ld1_c0", stall1, 1); check("ld3_c0", stall3, 1);
    tick(); dx_ir = NOP;
    settle(); check("ld1_c1", stall1, 0); check("ld3_c1", stall3, 1);
    tick();
    settle(); check("ld3_c2", stall3, 1);
    tick();
    settle(); check("ld3_c3", stall3, 0);
    drain();

    // lw r7, dependent addi two slots later
    dx_ir = itype(LW, 5'd7, 5'd1, 17'd0); fd_ir = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    settle(); check("gap_c0", stall3, 0);
    tick(); dx_ir = rtype(5'd1, 5'd2, 5'd3, 5'd0); fd_ir = rtype(5'd10, 5'd11, 5'd12, 5'd0);
    settle(); check("gap_c1", stall3, 0);
    tick(); dx_ir = rtype(5'd10, 5'd11, 5'd12, 5'd0); fd_ir = itype(ADDI, 5'd8, 5'd7, 17'd1);
    settle(); check("gap_c2", stall3, 1);
    tick(); dx_ir = NOP;
    settle(); check("gap_c3", stall3, 0);
    drain();

    // same with lw r0
    dx_ir = itype(LW, 5'd0, 5'd1, 17'd0); fd_ir = itype(ADDI, 5'd8, 5'd0, 17'd1);
    settle(); check("r0_c0", stall3, 0);
    tick(); dx_ir = NOP;
    settle(); check("r0_c1", stall3, 0);
    tick();
    settle(); check("r0_c2", stall3, 0);
    drain();

    // sw r3 behind lw r3, then flush
    dx_ir = itype(LW, 5'd3, 5'd1, 17'd0); fd_ir = itype(SW, 5'd3, 5'd1, 17'd0);
    settle(); check("sw_c0", stall3, 1);
    tick(); dx_ir = NOP;
    settle(); check("sw_c1", stall3, 1);
    flush = 1'b1;
    #1; check("sw_flush", stall3, 0);
    tick(); flush = 1'b0;
    settle(); check("sw_cleared", stall3, 0);
    drain();

    // bex reads r30 through the shadow pipe
    dx_ir = itype(LW, 5'd30, 5'd1, 17'd0); fd_ir = NOP;
    tick(); dx_ir = NOP; fd_ir = {5'b10110, 27'd0};
    settle(); check("bex_sh", stall3, 1); check("bex_l1", stall1, 0);
    drain();

    // mul r9, md_ready 5 cycles after start; md_ready in the issue cycle is ignored
    dx_ir = rtype(5'd9, 5'd1, 5'd2, 5'b00110); fd_ir = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    md_ready = 1'b1;
    settle(); check("mul_start", md_start1, 1); check("mul_stall0", stall1, 1);
    check("mul_busy0", md_busy1, 0);
    tick(); dx_ir = NOP; md_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("mul_busy", md_busy1, 1); check("mul_nostart", md_start1, 0);
      check("mul_stall", stall1, BLK); check("mul_rd", md_rd1, 9);
      tick();
    end
    md_ready = 1'b1;
    settle(); check("mul_busy5", md_busy1, 1); check("mul_rdy_stall", stall1, 0);
    tick(); md_ready = 1'b0;
    settle(); check("mul_idle", md_busy1, 0); check("mul_after", stall1, 0);
    drain();

    // div r9 with dependent add r1,r9,r3; a second mul in D/X is held off
    dx_ir = rtype(5'd9, 5'd1, 5'd2, 5'b00111); fd_ir = rtype(5'd1, 5'd9, 5'd3, 5'd0);
    settle(); check("div_start", md_start1, 1);
    tick(); dx_ir = NOP;
    settle(); check("div_dep_c1", stall1, 1);
    tick(); dx_ir = rtype(5'd5, 5'd1, 5'd2, 5'b00110);
    settle(); check("div_2nd_nostart", md_start1, 0); check("div_2nd_stall", stall1, 1);
    check("div_rd_kept", md_rd1, 9);
    tick(); dx_ir = NOP; md_ready = 1'b1;
    settle(); check("div_rdy", stall1, 0);
    tick(); md_ready = 1'b0;
    settle(); check("div_idle", md_busy1, 0);
    drain();

    // watchdog: MD_TIMEOUT=8, md_ready never comes
    dx_ir = rtype(5'd9, 5'd1, 5'd2, 5'b00110); fd_ir = rtype(5'd1, 5'd9, 5'd3, 5'd0);
    settle(); check("to_start", md_start3, 1);
    tick(); dx_ir = NOP;
    for (int i = 1; i <= 7; i++) begin
      settle(); check("to_quiet", md_timeout3, 0); check("to_stall", stall3, 1);
      tick();
    end
    settle(); check("to_pulse", md_timeout3, 1); check("to_fire_stall", stall3, 0);
    check("to_busy8", md_busy3, 1);
    tick();
    settle(); check("to_idle", md_busy3, 0); check("to_after", md_timeout3, 0);
    check("to_nostall", stall3, 0);
    drain();

    // reset while busy
    dx_ir = rtype(5'd9, 5'd1, 5'd2, 5'b00110);
    tick(); dx_ir = NOP;
    tick();
    settle(); check("rb_busy_pre", md_busy1, 1);
    tick(); reset_n = 1'b0;
    #1; check("rb_busy", md_busy1, 0); check("rb_timeout", md_timeout1, 0);
    check("rb_md_rd", md_rd1, 0);
    for (int i = 0; i < 8; i++) begin
      settle(); check("rb_no_to", md_timeout1, 0);
    end
    reset_n = 1'b1;
    tick();
    settle(); check("rb_after", md_busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
